// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   lsu_state_t : access sequencer states.
//   F3_*        : funct3 encodings for access size and load sign handling.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   funct3_i   : access size/sign
//   addr_lo_i  : byte offset within the word
//   we_i       : 1 = store, 0 = load
//   wdata_i    : right-aligned store data
//   rdata_i    : raw bus read word
//   be_o       : byte enables for the access
//   wdata_o    : store data replicated across lanes
//   rdata_o    : load data shifted down and sign/zero extended
//   misalign_o : offset not aligned to the access size
//   illegal_o  : funct3 not a valid load/store encoding
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic        illegal_o
);

   logic [31:0] shifted;

   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = wdata_i;
      misalign_o = 1'b0;

      if (we_i) begin
         illegal_o = (funct3_i >= 3'b011);
      end else begin
         illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      end

      // Size is funct3[1:0]; funct3[2] only selects load zero-extension.
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o       = 4'b0011 << addr_lo_i;
            wdata_o    = {2{wdata_i[15:0]}};
            misalign_o = addr_lo_i[0];
         end
         2'b10: begin
            be_o       = 4'b1111;
            misalign_o = |addr_lo_i;
         end
         default: begin
            be_o = 4'b0000;
         end
      endcase

      if (illegal_o) begin
         be_o       = 4'b0000;
         misalign_o = 1'b0;
      end
   end

   always_comb begin
      shifted = rdata_i >> {addr_lo_i, 3'b000};
      case (funct3_i)
         F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   rdata_o = {24'd0, shifted[7:0]};
         F3_HU:   rdata_o = {16'd0, shifted[15:0]};
         default: rdata_o = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit driving a req/gnt/rvalid data bus.
//   clk, reset            : clock, synchronous active-high reset
//   memreadM, memwriteM   : MEM-stage load / store (both set = store)
//   funct3M, addrM        : access size/sign and byte address
//   writedataM            : right-aligned store data
//   readdataM             : extended load result, valid in DONE (0 otherwise)
//   stallM                : hold the pipeline while an access is in flight
//   errM                  : one-cycle pulse on a misaligned/illegal access
//   bus_req/we/addr/wdata/be : registered request, held until bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata : bus handshake and read return
module dmem_lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        errM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   lsu_state_t  state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        access, idle;
   logic [2:0]  al_f3;
   logic [1:0]  al_off;
   logic        al_we;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;
   logic        al_misalign, al_illegal, bad, start;

   assign access = memreadM | memwriteM;
   assign idle   = (state_q == IDLE);

   // One aligner serves both directions: in IDLE it checks and steers the
   // incoming request, afterwards it extracts load data with latched size/offset.
   assign al_f3  = idle ? funct3M    : f3_q;
   assign al_off = idle ? addrM[1:0] : off_q;
   assign al_we  = idle ? memwriteM  : we_q;

   lsu_align u_align (
      .funct3_i   (al_f3),
      .addr_lo_i  (al_off),
      .we_i       (al_we),
      .wdata_i    (writedataM),
      .rdata_i    (bus_rdata),
      .be_o       (al_be),
      .wdata_o    (al_wdata),
      .rdata_o    (al_rdata),
      .misalign_o (al_misalign),
      .illegal_o  (al_illegal)
   );

   assign bad   = al_misalign | al_illegal;
   assign start = !reset && idle && access && !bad;

   always_comb begin
      state_d = state_q;
      stallM  = 1'b0;
      errM    = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (bad) begin
                  errM = 1'b1;
               end else begin
                  stallM  = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            stallM = 1'b1;
            if (bus_gnt) state_d = we_q ? DONE : WAIT;
         end
         WAIT: begin
            stallM = 1'b1;
            if (bus_rvalid) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (reset) begin
         state_d = IDLE;
         stallM  = 1'b0;
         errM    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (start) begin
            addr_q  <= {addrM[31:2], 2'b00};
            wdata_q <= memwriteM ? al_wdata : 32'd0;
            be_q    <= al_be;
            we_q    <= memwriteM;
            f3_q    <= funct3M;
            off_q   <= addrM[1:0];
            rdata_q <= 32'd0;
         end else if ((state_q == WAIT) && bus_rvalid) begin
            rdata_q <= al_rdata;
         end
      end
   end

   assign bus_req   = (state_q == REQ);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_be    = be_q;
   // Only the DONE cycle presents a result; everything else reads as 0.
   assign readdataM = (state_q == DONE) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        memreadM, memwriteM;
   logic [2:0]  funct3M;
   logic [31:0] addrM, writedataM;
   logic [31:0] readdataM;
   logic        stallM, errM;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int rise_cnt = 0;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   dmem_lsu dut (
      .clk        (clk),
      .reset      (reset),
      .memreadM   (memreadM),
      .memwriteM  (memwriteM),
      .funct3M    (funct3M),
      .addrM      (addrM),
      .writedataM (writedataM),
      .readdataM  (readdataM),
      .stallM     (stallM),
      .errM       (errM),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_be     (bus_be),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   // Counts bus requests so duplicate or phantom requests show up.
   always @(negedge clk) begin
      if (bus_req && !req_prev) rise_cnt++;
      req_prev = bus_req;
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          gd;
      int          rvd;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_cycle();
      memreadM  = 1'b0;
      memwriteM = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Runs one access from IDLE through its DONE (or error) cycle; leaves the
   // request inputs asserted so the caller can issue a back-to-back access.
   task automatic run_access(input vec_t v, input string tag);
      int  stalls = 0;
      int  reqc = 0;
      int  waitc = 0;
      bit  gnt_given = 0;
      bit  done = 0;
      int  exp_stalls;
      memreadM   = v.rd;
      memwriteM  = v.wr;
      funct3M    = v.f3;
      addrM      = v.addr;
      writedataM = v.wd;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         bus_rdata  = 32'h5A5A_A5A5;
         if (stallM) stalls++;
         if (bus_req) begin
            reqc++;
            chk({tag, " bus_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
            chk({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, v.exp_be});
            chk({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, v.wr});
            if (v.wr) chk({tag, " bus_wdata"}, bus_wdata, v.exp_wd);
            // Spurious rvalid during REQ must be ignored.
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hBAD0_BAD0;
            if (reqc > v.gd) begin
               bus_gnt   = 1'b1;
               gnt_given = 1;
            end
         end else if (stallM && gnt_given) begin
            waitc++;
            if (waitc > v.rvd) begin
               bus_rvalid = 1'b1;
               bus_rdata  = v.rdata;
            end
         end else if (!stallM) begin
            chk({tag, " errM"}, {31'd0, errM}, {31'd0, v.exp_err});
            chk({tag, " readdataM"}, readdataM, v.exp_rd);
            done = 1;
         end
         @(posedge clk);
         #1;
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s timeout: no completion within 40 cycles", tag);
      end
      if (v.exp_err) exp_stalls = 0;
      else if (v.wr) exp_stalls = 2 + v.gd;
      else exp_stalls = 3 + v.gd + v.rvd;
      chk({tag, " stall cycles"}, stalls, exp_stalls);
   endtask

   initial begin
      int r0;
      vec_t sh;
      vec_t b2b0, b2b1;

      //          rd    wr    f3      addr          wd            rdata        gd rvd be       exp_wd        exp_rd        err
      vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'h80FF_1234, 0, 0, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h80FF_1234, 1, 2, 4'b1000, 32'h0,         32'h0000_0080, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0201, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1234_5678, 2, 1, 4'b1111, 32'h0,         32'h1234_5678, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h80FF_1234, 0, 1, 4'b1100, 32'h0,         32'hFFFF_80FF, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         32'h80FF_1234, 1, 0, 4'b1100, 32'h0,         32'h0000_80FF, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0,         32'h80FF_1234, 0, 0, 4'b0010, 32'h0,         32'h0000_0012, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
      vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,        1'b1};
      vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0};
      vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0,         32'h0000_7FFF, 0, 0, 4'b0011, 32'h0,         32'h0000_7FFF, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0,         32'h0,        0, 0, 4'b0000, 32'h0,         32'h0,        1'b1};

      reset      = 1'b1;
      memreadM   = 1'b0;
      memwriteM  = 1'b0;
      funct3M    = 3'b000;
      addrM      = 32'd0;
      writedataM = 32'd0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset bus_req", {31'd0, bus_req}, 32'd0);
      chk("reset bus_we", {31'd0, bus_we}, 32'd0);
      chk("reset bus_addr", bus_addr, 32'd0);
      chk("reset bus_wdata", bus_wdata, 32'd0);
      chk("reset bus_be", {28'd0, bus_be}, 32'd0);
      chk("reset readdataM", readdataM, 32'd0);
      chk("reset errM", {31'd0, errM}, 32'd0);
      chk("reset stallM", {31'd0, stallM}, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         r0 = rise_cnt;
         run_access(vecs[i], $sformatf("vec%0d", i));
         idle_cycle();
         chk($sformatf("vec%0d bus requests", i), rise_cnt - r0, vecs[i].exp_err ? 0 : 1);
      end

      // SH with grant held off for 4 REQ cycles; bus fields checked every REQ cycle.
      sh = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 4, 0,
             4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0};
      r0 = rise_cnt;
      run_access(sh, "sh_gnt4");
      idle_cycle();
      chk("sh_gnt4 bus requests", rise_cnt - r0, 1);

      // Reset while waiting for read data, then a late rvalid.
      r0 = rise_cnt;
      memreadM = 1'b1;
      funct3M  = 3'b010;
      addrM    = 32'h0000_0040;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      bus_gnt = 1'b1;
      @(posedge clk);
      #1;
      bus_gnt = 1'b0;
      @(negedge clk);
      chk("rst_wait in WAIT stallM", {31'd0, stallM}, 32'd1);
      chk("rst_wait in WAIT bus_req", {31'd0, bus_req}, 32'd0);
      reset    = 1'b1;
      memreadM = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_wait after edge bus_req", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      chk("rst_wait idle stallM", {31'd0, stallM}, 32'd0);
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_wait readdataM", readdataM, 32'd0);
         chk("rst_wait bus_req", {31'd0, bus_req}, 32'd0);
      end
      @(posedge clk);
      #1;
      chk("rst_wait bus requests", rise_cnt - r0, 1);

      // Back-to-back LW then SW with no idle gap between them.
      b2b0 = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 0, 0,
               4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0};
      b2b1 = '{1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h7654_3210, 32'h0, 0, 0,
               4'b1111, 32'h7654_3210, 32'h0, 1'b0};
      r0 = rise_cnt;
      run_access(b2b0, "b2b_lw");
      run_access(b2b1, "b2b_sw");
      idle_cycle();
      idle_cycle();
      chk("b2b bus requests", rise_cnt - r0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
